nibble_serial_add_arbiter: RTL and testbench

//  Shares one 4-bit ripple-carry adder slice (full-adder chain) between two requesters.

---
 rtl/nibble_serial_add_arbiter.sv | 102 ++++++++++
 tb/tb_nibble_serial_add_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_arbiter.sv
// Two-requester round-robin front end for a single 4-bit adder slice. Each accepted
// operation is summed one nibble per cycle, LSB first, then held until the consumer takes it.
module nibble_serial_add_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             busy
);
    localparam int NNIB = WIDTH / 4;
    localparam int NIBW = (NNIB > 1) ? $clog2(NNIB) : 1;

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t            state;
    logic              prio;
    logic              carry;
    logic [NIBW-1:0]   nib;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic              grant0;
    logic              grant1;
    logic [4:0]        nsum;
    logic [WIDTH+3:0]  sum_ins;

    always_comb begin
        grant0 = req0_valid & (~req1_valid | ~prio);
        grant1 = req1_valid & (~req0_valid | prio);
    end

    // Ready is masked by rst_n so nothing is offered while reset is held.
    assign req0_ready = rst_n & (state == IDLE) & grant0;
    assign req1_ready = rst_n & (state == IDLE) & grant1;
    assign rsp_valid  = (state == RESP);
    assign busy       = (state != IDLE);

    // Operands shift right one nibble per step; sum nibbles shift in from the top,
    // so after NNIB steps the first nibble has landed in bits [3:0].
    always_comb begin
        nsum    = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0000, carry};
        sum_ins = {nsum[3:0], rsp_sum};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            prio     <= 1'b0;
            carry    <= 1'b0;
            nib      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            rsp_id   <= 1'b0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready | req1_ready) begin
                        a_sh   <= req1_ready ? req1_a   : req0_a;
                        b_sh   <= req1_ready ? req1_b   : req0_b;
                        carry  <= req1_ready ? req1_cin : req0_cin;
                        rsp_id <= req1_ready;
                        prio   <= ~req1_ready;
                        nib    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    a_sh    <= a_sh >> 4;
                    b_sh    <= b_sh >> 4;
                    carry   <= nsum[4];
                    rsp_sum <= sum_ins[WIDTH+3:4];
                    nib     <= nib + 1'b1;
                    if (nib == NIBW'(NNIB - 1)) begin
                        rsp_cout <= nsum[4];
                        state    <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_add_arbiter.sv
// Randomized bench for nibble_serial_add_arbiter: a transaction-level model (timer plus
// plain A+B+cin arithmetic) is compared with the DUT every cycle, plus literal checks.
module tb_nibble_serial_add_arbiter;
    localparam int W    = 16;
    localparam int NNIB = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req0_cin;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_cin;
    logic [W-1:0] req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
    logic [W-1:0] rsp_sum;

    nibble_serial_add_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_cin(req1_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Model: idle, or counting down the NNIB calc cycles, or holding a result.
    int           m_wait;
    bit           m_resp, m_prio, m_id, m_cout;
    logic [W-1:0] m_sum;
    bit           obs0, obs1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_wait = 0; m_resp = 0; m_prio = 0; m_id = 0; m_cout = 0; m_sum = '0;
    endtask

    task automatic step(input bit v0, input logic [W-1:0] a0, input logic [W-1:0] b0, input bit c0,
                        input bit v1, input logic [W-1:0] a1, input logic [W-1:0] b1, input bit c1,
                        input bit rr, input bit rn);
        bit idle, e0, e1;
        logic [W:0] full;
        @(negedge clk);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1;
        rsp_ready = rr; rst_n = rn;
        #1;
        if (!rn) model_reset();
        idle = (m_wait == 0) && !m_resp;
        e0 = rn && idle && v0 && (!v1 || !m_prio);
        e1 = rn && idle && v1 && (!v0 || m_prio);
        obs0 = req0_ready; obs1 = req1_ready;
        chk("req0_ready", {31'b0, req0_ready}, {31'b0, e0});
        chk("req1_ready", {31'b0, req1_ready}, {31'b0, e1});
        chk("rsp_valid",  {31'b0, rsp_valid},  {31'b0, m_resp});
        chk("busy",       {31'b0, busy},       {31'b0, !idle});
        if (idle || m_resp) begin
            chk("rsp_id",   {31'b0, rsp_id},   {31'b0, m_id});
            chk("rsp_sum",  {16'b0, rsp_sum},  {16'b0, m_sum});
            chk("rsp_cout", {31'b0, rsp_cout}, {31'b0, m_cout});
        end
        @(posedge clk);
        cyc++;
        if (rn) begin
            if (e0 || e1) begin
                full   = e1 ? ({1'b0, a1} + {1'b0, b1} + {{W{1'b0}}, c1})
                            : ({1'b0, a0} + {1'b0, b0} + {{W{1'b0}}, c0});
                m_sum  = full[W-1:0];
                m_cout = full[W];
                m_id   = e1;
                m_prio = !e1;
                m_wait = NNIB;
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) m_resp = 1;
            end else if (m_resp && rr) begin
                m_resp = 0;
            end
        end
    endtask

    task automatic idle_steps(input int n, input bit rr);
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0, '0, '0, 0, rr, 1);
    endtask

    int acc_cyc[$];
    int acc_id[$];

    initial begin
        rst_n = 0; rsp_ready = 0;
        req0_valid = 0; req0_a = '0; req0_b = '0; req0_cin = 0;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_cin = 0;
        model_reset();

        // Reset with both requesters valid: nothing granted, everything 0.
        step(1, 16'h1111, 16'h2222, 0, 1, 16'h3333, 16'h4444, 0, 1, 0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        step(1, 16'h1111, 16'h2222, 0, 1, 16'h3333, 16'h4444, 0, 1, 1);
        chk("first_grant_req0", {30'b0, obs1, obs0}, 32'd1);
        idle_steps(NNIB + 2, 1);

        // req0: 1234 + 0FFF + 0 = 2233.
        step(1, 16'h1234, 16'h0FFF, 0, 0, '0, '0, 0, 1, 1);
        idle_steps(NNIB, 1);
        #2;
        chk("t2_valid", {31'b0, rsp_valid}, 32'd1);
        chk("t2_sum",   {16'b0, rsp_sum},   32'h2233);
        chk("t2_cout",  {31'b0, rsp_cout},  32'd0);
        chk("t2_id",    {31'b0, rsp_id},    32'd0);
        chk("t2_model", {15'b0, m_cout, m_sum}, 32'h02233);
        idle_steps(2, 1);

        // req1: FFFF + 0000 + 1 ripples all the way out.
        step(0, '0, '0, 0, 1, 16'hFFFF, 16'h0000, 1, 1, 1);
        idle_steps(NNIB, 1);
        #2;
        chk("t3_valid", {31'b0, rsp_valid}, 32'd1);
        chk("t3_sum",   {16'b0, rsp_sum},   32'h0000);
        chk("t3_cout",  {31'b0, rsp_cout},  32'd1);
        chk("t3_id",    {31'b0, rsp_id},    32'd1);
        chk("t3_model", {15'b0, m_cout, m_sum}, 32'h10000);
        idle_steps(2, 1);

        // Both valid continuously: alternate grants, one every NNIB+2 cycles.
        for (int i = 0; i < 4 * (NNIB + 2); i++) begin
            step(1, 16'(i), 16'(3 * i), 0, 1, 16'(7 * i), 16'h8000, 1, 1, 1);
            if (obs0 || obs1) begin
                acc_cyc.push_back(cyc);
                acc_id.push_back(int'(obs1));
            end
        end
        chk("t4_count", 32'(acc_id.size()), 32'd4);
        if (acc_id.size() == 4) begin
            chk("t4_seq", 32'({acc_id[0][3:0], acc_id[1][3:0], acc_id[2][3:0], acc_id[3][3:0]}), 32'h0101);
            for (int i = 1; i < 4; i++)
                chk("t4_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(NNIB + 2));
        end
        idle_steps(NNIB + 2, 1);

        // Consumer stalls for 5 cycles in RESP; result held, requests refused.
        step(1, 16'hABCD, 16'h1111, 1, 0, '0, '0, 0, 0, 1);
        idle_steps(NNIB, 0);
        for (int i = 0; i < 5; i++) step(1, 16'h5555, 16'h5555, 0, 1, 16'h6666, 16'h0001, 0, 0, 1);
        chk("t5_sum_held", {16'b0, rsp_sum}, 32'hBCDF);
        step(1, 16'h5555, 16'h5555, 0, 1, 16'h6666, 16'h0001, 0, 1, 1);
        step(1, 16'h5555, 16'h5555, 0, 1, 16'h6666, 16'h0001, 0, 1, 1);
        chk("t5_next_accept", {30'b0, obs1, obs0}, 32'd2);
        idle_steps(NNIB + 2, 1);

        // Reset pulsed mid-calculation, then a fresh request.
        step(1, 16'h00F0, 16'h0F10, 0, 0, '0, '0, 0, 1, 1);
        idle_steps(1, 1);
        step(0, '0, '0, 0, 0, '0, '0, 0, 1, 0);
        chk("t6_rst_busy", {31'b0, busy}, 32'd0);
        chk("t6_rst_sum",  {16'b0, rsp_sum}, 32'd0);
        step(1, 16'h7FFF, 16'h8001, 0, 1, 16'h1, 16'h1, 0, 1, 1);
        idle_steps(NNIB, 1);
        #2;
        chk("t6_sum",  {16'b0, rsp_sum},  32'h0000);
        chk("t6_cout", {31'b0, rsp_cout}, 32'd1);
        chk("t6_id",   {31'b0, rsp_id},   32'd0);
        idle_steps(2, 1);

        // Random traffic, backpressure and occasional resets.
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 99) != 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
